// File: rtl/fwvip_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_INIT initiators share one target port.
// Grant is held for a whole CYC; a watchdog aborts stalled strobes with ERR.
module fwvip_wb_rr_arbiter #(
   parameter int unsigned N_INIT        = 4,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MAX_CYCLE_LEN = 256
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [N_INIT-1:0]                i_cyc,
   input  logic [N_INIT-1:0]                i_stb,
   input  logic [N_INIT-1:0]                i_we,
   input  logic [N_INIT*ADDR_WIDTH-1:0]     i_adr,
   input  logic [N_INIT*DATA_WIDTH-1:0]     i_dat_w,
   input  logic [N_INIT*DATA_WIDTH/8-1:0]   i_sel,
   output logic [DATA_WIDTH-1:0]            i_dat_r,
   output logic [N_INIT-1:0]                i_ack,
   output logic [N_INIT-1:0]                i_err,
   output logic                             t_cyc,
   output logic                             t_stb,
   output logic                             t_we,
   output logic [ADDR_WIDTH-1:0]            t_adr,
   output logic [DATA_WIDTH-1:0]            t_dat_w,
   output logic [DATA_WIDTH/8-1:0]          t_sel,
   input  logic [DATA_WIDTH-1:0]            t_dat_r,
   input  logic                             t_ack,
   input  logic                             t_err,
   output logic [N_INIT-1:0]                gnt,
   output logic                             timeout
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned OWN_W     = $clog2(N_INIT);
   localparam int unsigned WD_W      = $clog2(MAX_CYCLE_LEN) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [OWN_W-1:0]    last_q, last_d;
   logic [N_INIT-1:0]   gnt_q, gnt_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic                own_cyc;
   logic                own_stb;
   logic                found;
   int unsigned         idx;

   assign i_dat_r = t_dat_r;
   assign gnt     = gnt_q;
   assign own_cyc = i_cyc[owner_q];
   assign own_stb = i_stb[owner_q] & own_cyc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= OWN_W'(N_INIT - 1);
         gnt_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      wdog_d  = '0;
      found   = 1'b0;
      idx     = 0;
      t_cyc   = 1'b0;
      t_stb   = 1'b0;
      t_we    = 1'b0;
      t_adr   = '0;
      t_dat_w = '0;
      t_sel   = '0;
      i_ack   = '0;
      i_err   = '0;
      timeout = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Scan from the initiator after the last owner, wrapping.
            for (int unsigned i = 1; i <= N_INIT; i++) begin
               idx = (32'(last_q) + i) % N_INIT;
               if (!found && i_cyc[OWN_W'(idx)]) begin
                  found   = 1'b1;
                  owner_d = OWN_W'(idx);
               end
            end
            if (found) begin
               gnt_d   = N_INIT'(1) << owner_d;
               last_d  = owner_d;
               state_d = ST_OWN;
            end
         end

         ST_OWN: begin
            t_cyc   = own_cyc;
            t_stb   = own_stb;
            t_we    = i_we[owner_q];
            t_adr   = i_adr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
            t_dat_w = i_dat_w[owner_q*DATA_WIDTH +: DATA_WIDTH];
            t_sel   = i_sel[owner_q*SEL_WIDTH +: SEL_WIDTH];
            if (own_stb && t_ack) i_ack = gnt_q;
            if (own_stb && t_err) i_err = gnt_q;
            if (!own_cyc) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (own_stb && !t_ack && !t_err) begin
               // A response in the limit cycle clears the count and wins.
               wdog_d = wdog_q + WD_W'(1);
               if (wdog_d == WD_W'(MAX_CYCLE_LEN)) state_d = ST_ABORT;
            end
         end

         ST_ABORT: begin
            i_err   = gnt_q;
            timeout = 1'b1;
            state_d = ST_IDLE;
            gnt_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

endmodule
